// File: rtl/rot_pkg.sv
// rot_pkg -- shared definitions for the rotate/shift arbiter.
//   OPW              : opcode width (3 bits)
//   op_e             : opcode constants ROL, ROR, SLL, SRL, SRA
//   state_e          : result-register occupancy (EMPTY / FULL)
package rot_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rot_core32.sv
// rot_core32 -- combinational 32-bit rotator.
//   a   : operand
//   amt : rotate amount (0..31)
//   dir : 0 = rotate left, 1 = rotate right
//   y   : rotated operand
module rot_core32 (
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  input  logic        dir,
  output logic [31:0] y
);

  logic [63:0] dbl;
  logic [63:0] lsh;
  logic [63:0] rsh;

  // Shifting a doubled copy of the operand turns a rotate into a plain shift:
  // the bits falling off one end reappear from the other copy.
  always_comb begin
    dbl = {a, a};
    lsh = dbl << amt;
    rsh = dbl >> amt;
    y   = dir ? rsh[31:0] : lsh[63:32];
  end

endmodule

// File: rtl/rot_arbiter.sv
// rot_arbiter -- two requesters share one rotate/shift datapath and one
// result register, arbitrated round-robin.
//   clk, reset                    : clock, synchronous active-high reset
//   rN_valid / rN_ready           : requester N handshake (N = 0, 1)
//   rN_op, rN_A, rN_shr, rN_tag   : opcode, operand, amount, opaque tag
//   resp_valid / resp_ready       : result handshake
//   resp_OUT, resp_id, resp_tag   : result, source requester, echoed tag
//   fsm_state                     : result-register state (debug)
// Optional feature: define ROT_ARBITER_SRA_EN to add op 100 (SRA); without
// it op 100 is illegal and returns 0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. rN_ready is combinational and never depends on a later cycle;
// resp_* hold stable while resp_valid = 1 and resp_ready = 0.
module rot_arbiter
  import rot_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [OPW-1:0]  r0_op,
  input  logic [31:0]     r0_A,
  input  logic [4:0]      r0_shr,
  input  logic [TAGW-1:0] r0_tag,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [OPW-1:0]  r1_op,
  input  logic [31:0]     r1_A,
  input  logic [4:0]      r1_shr,
  input  logic [TAGW-1:0] r1_tag,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_OUT,
  output logic            resp_id,
  output logic [TAGW-1:0] resp_tag,
  output state_e          fsm_state
);

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  state_e          state_q;
  state_e          state_d;
  logic            ptr;
  logic            can_accept;
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic [OPW-1:0]  sel_op;
  logic [31:0]     sel_a;
  logic [4:0]      sel_shr;
  logic [TAGW-1:0] sel_tag;
  logic            rot_dir;
  logic [31:0]     rot_y;
  logic [31:0]     result;

  // Arbitration: sole valid requester wins; on contention the pointer decides.
  always_comb begin
    can_accept = !reset && ((state_q == EMPTY) || resp_ready);
    grant0     = r0_valid && (!r1_valid || (ptr == 1'b0));
    grant1     = r1_valid && (!r0_valid || (ptr == 1'b1));
    r0_ready   = can_accept && grant0;
    r1_ready   = can_accept && grant1;
    accept     = r0_ready || r1_ready;
  end

  always_comb begin
    sel_op  = grant1 ? r1_op  : r0_op;
    sel_a   = grant1 ? r1_A   : r0_A;
    sel_shr = grant1 ? r1_shr : r0_shr;
    sel_tag = grant1 ? r1_tag : r0_tag;
  end

  // Right-going ops use the right rotate; logical/arith shifts then mask off
  // the bits that wrapped around.
  always_comb begin
    rot_dir = 1'b0;
    case (sel_op)
      OP_ROR, OP_SRL, OP_SRA: rot_dir = 1'b1;
      default:                rot_dir = 1'b0;
    endcase
  end

  rot_core32 u_core (
    .a   (sel_a),
    .amt (sel_shr),
    .dir (rot_dir),
    .y   (rot_y)
  );

  always_comb begin
    result = '0;
    case (sel_op)
      OP_ROL:  result = rot_y;
      OP_ROR:  result = rot_y;
      OP_SLL:  result = rot_y & (ONES << sel_shr);
      OP_SRL:  result = rot_y & (ONES >> sel_shr);
`ifdef ROT_ARBITER_SRA_EN
      // Same as SRL, then the cleared high bits are filled with the sign.
      OP_SRA:  result = (rot_y & (ONES >> sel_shr))
                      | (sel_a[31] ? ~(ONES >> sel_shr) : 32'h0);
`endif
      default: result = '0;
    endcase
  end

  // Result-register occupancy FSM.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)                               state_d = FULL;
    else if ((state_q == FULL) && resp_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_OUT <= '0;
      resp_id  <= 1'b0;
      resp_tag <= '0;
      ptr      <= 1'b0;
    end else if (accept) begin
      resp_OUT <= result;
      resp_id  <= grant1;
      resp_tag <= sel_tag;
      ptr      <= ~grant1;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign fsm_state  = state_q;

endmodule

// File: doc/rot_arbiter.md
ROT_ARBITER -- requirements
Module: rot_arbiter

Interface
REQ-001 SHALL have parameter TAGW, default 4, width of the per-request tag returned with the result.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports r0_valid / r1_valid, input, 1 each, the requester has an operation pending.
REQ-005 SHALL have ports r0_ready / r1_ready, output, 1 each, the operation is accepted this cycle.
REQ-006 SHALL have ports r0_op / r1_op, input, 3 each, the operation code.
REQ-007 SHALL have ports r0_A / r1_A, input, 32 each, the operand.
REQ-008 SHALL have ports r0_shr / r1_shr, input, 5 each, the shift or rotate amount.
REQ-009 SHALL have ports r0_tag / r1_tag, input, TAGW each, an opaque tag.
REQ-010 SHALL have port resp_valid, output, 1, a result is held.
REQ-011 SHALL have port resp_ready, input, 1, the consumer takes the result.
REQ-012 SHALL have port resp_OUT, output, 32, the result.
REQ-013 SHALL have port resp_id, output, 1, the source requester (0/1).
REQ-014 SHALL have port resp_tag, output, TAGW, the echoed tag.

Function
REQ-015 SHALL share one 32-bit rotate datapath between two requesters, with one result register.
REQ-016 SHALL decode op as: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA (REQ-031); any other code is illegal and yields resp_OUT = 0.
REQ-017 SHALL form SLL/SRL by ANDing the rotate output with a mask: the shr low bits cleared for SLL, the shr high bits cleared for SRL; shr = 0 passes A unchanged for every legal op.
REQ-018 SHALL use states EMPTY and FULL; the result register holds exactly one result.
REQ-019 SHALL accept a request when the state is EMPTY, or when it is FULL and resp_ready = 1 in the same cycle (back-to-back throughput of 1 per cycle).
REQ-020 SHALL set at most one of r0_ready / r1_ready per cycle; ready is combinational from valid, state, resp_ready and the priority pointer.
REQ-021 SHALL grant the sole valid requester when only one is valid; when both are valid, SHALL grant the requester named by the round-robin pointer.
REQ-022 SHALL set the pointer to the non-granted requester after every accepted transfer; the pointer is unchanged when nothing is accepted.
REQ-023 SHALL update resp_OUT / resp_id / resp_tag one cycle after acceptance (latency 1) and set resp_valid = 1.
REQ-024 SHALL hold resp_* stable while resp_valid = 1 and resp_ready = 0.
REQ-025 SHALL return to EMPTY (resp_valid = 0) on a cycle with resp_valid = 1, resp_ready = 1 and no new acceptance.
REQ-026 SHALL ignore requester inputs in any cycle where the matching ready is 0; a requester may not rely on a dropped valid being remembered.

Reset
REQ-027 SHALL, while reset = 1, force state EMPTY, resp_valid = 0, resp_OUT = 0, resp_id = 0, resp_tag = 0, pointer = 0, and r0_ready = r1_ready = 0.
REQ-028 SHALL discard any held result on reset asserted mid-operation; the first cycle after reset deasserts behaves as EMPTY with requester 0 preferred.

Configuration
REQ-029 SHALL compile op 100 (SRA) in only when macro ROT_ARBITER_SRA_EN is defined.
REQ-030 SHALL, with ROT_ARBITER_SRA_EN defined, implement SRA as the SRL result with the vacated high bits filled with A[31].
REQ-031 SHALL, without ROT_ARBITER_SRA_EN, treat op 100 as illegal (result 0) and contain no sign-fill logic.

Structure
REQ-032 SHALL take the opcode constants (ROL, ROR, SLL, SRL, SRA) and the 3-bit op width from the shared package rot_pkg.
REQ-033 SHALL instantiate one sub-module, rot_core32 (combinational 32-bit left/right rotate by 5-bit amount), exactly once; masking and arbitration remain in rot_arbiter.

Verification
REQ-034 SHALL cover: r0 ROR A=0x00000001 shr=1 -> next cycle resp_OUT=0x80000000, resp_id=0.
REQ-035 SHALL cover: r0 and r1 both valid continuously after reset with resp_ready=1 -> grants alternate r0, r1, r0, r1, one result per cycle.
REQ-036 SHALL cover: resp_ready=0 for 3 cycles with a result held -> r0_ready = r1_ready = 0 and resp_* stable; resp_ready=1 -> held result retires and a new request is accepted in the same cycle.
REQ-037 SHALL cover: SLL 0xFFFFFFFF by 4 -> 0xFFFFFFF0; SRL 0xFFFFFFFF by 4 -> 0x0FFFFFFF; op 111 -> 0.
REQ-038 SHALL cover: SRA 0x80000000 by 4 -> 0xF8000000 with ROT_ARBITER_SRA_EN, 0x00000000 without.
REQ-039 SHALL cover: reset asserted while FULL -> resp_valid=0 the next cycle; with both requesters valid afterwards, r0 is granted first.
